// File: rtl/bounce_animator_if.sv
// bounce_animator_if: frame-tick inputs and centre/colour outputs between timing and overlay renderer
interface bounce_animator_if #(parameter int COLOR_W = 4);
  logic               i_frame_tick;
  logic               i_enable;
  logic [9:0]         o_centre_x;
  logic [8:0]         o_centre_y;
  logic               o_dir_x;
  logic               o_dir_y;
  logic [COLOR_W-1:0] o_red;
  logic [COLOR_W-1:0] o_green;
  logic [COLOR_W-1:0] o_blue;
  logic [1:0]         o_bounce;
  modport master (output i_frame_tick, i_enable,
                  input  o_centre_x, o_centre_y, o_dir_x, o_dir_y, o_red, o_green, o_blue, o_bounce);
  modport slave  (input  i_frame_tick, i_enable,
                  output o_centre_x, o_centre_y, o_dir_x, o_dir_y, o_red, o_green, o_blue, o_bounce);
endinterface

// File: rtl/bounce_animator.sv
// bounce_animator: frame-synchronous bouncing centre position and triangle-wave RGB colour engine
module bounce_animator #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int MARGIN    = 77,
  parameter int STEP_X    = 3,
  parameter int STEP_Y    = 1,
  parameter int MOVE_DIV  = 1,
  parameter int COLOR_DIV = 16,
  parameter int COLOR_W   = 4,
  parameter int STEP_R    = 1,
  parameter int STEP_G    = 2,
  parameter int STEP_B    = 3
) (
  input logic              clk,
  input logic              rst,
  bounce_animator_if.slave bus
);
  localparam logic [10:0] P_MIN = 11'(MARGIN);
  localparam logic [10:0] X_MAX = 11'(SCREEN_W - 1 - MARGIN);
  localparam logic [10:0] Y_MAX = 11'(SCREEN_H - 1 - MARGIN);
  localparam logic [10:0] SX = 11'(STEP_X);
  localparam logic [10:0] SY = 11'(STEP_Y);
  localparam logic [COLOR_W:0] C_MAX = {1'b0, {COLOR_W{1'b1}}};
  localparam int STEPS [3] = '{STEP_R, STEP_G, STEP_B};
  logic [15:0] r_move_cnt, r_col_cnt;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic        r_dx, r_dy;
  logic [1:0]  r_bounce;
  logic        w_run, w_move_stb, w_col_stb;
  logic [10:0] w_x_up, w_y_up;
  logic        w_x_hit, w_y_hit;
  logic [9:0]  w_x_nxt;
  logic [8:0]  w_y_nxt;
  logic [COLOR_W-1:0] w_col [3];
  assign w_run      = bus.i_frame_tick & bus.i_enable;
  assign w_move_stb = w_run & (r_move_cnt == 16'(MOVE_DIV - 1));
  assign w_col_stb  = w_move_stb & (r_col_cnt == 16'(COLOR_DIV - 1));
  // 11-bit arithmetic so the up-step never wraps; down test avoids underflow by moving STEP across
  assign w_x_up  = 11'(r_x) + SX;
  assign w_y_up  = 11'(r_y) + SY;
  assign w_x_hit = r_dx ? (11'(r_x) < P_MIN + SX) : (w_x_up > X_MAX);
  assign w_y_hit = r_dy ? (11'(r_y) < P_MIN + SY) : (w_y_up > Y_MAX);
  assign w_x_nxt = 10'(w_x_hit ? (r_dx ? P_MIN : X_MAX) : (r_dx ? 11'(r_x) - SX : w_x_up));
  assign w_y_nxt = 9'(w_y_hit ? (r_dy ? P_MIN : Y_MAX) : (r_dy ? 11'(r_y) - SY : w_y_up));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_move_cnt <= '0;
      r_col_cnt  <= '0;
      r_x        <= P_MIN[9:0];
      r_y        <= P_MIN[8:0];
      r_dx       <= 1'b0;
      r_dy       <= 1'b0;
      r_bounce   <= 2'b00;
    end else begin
      r_bounce <= 2'b00;
      if (w_run) r_move_cnt <= w_move_stb ? '0 : r_move_cnt + 16'd1;
      if (w_move_stb) begin
        r_col_cnt <= w_col_stb ? '0 : r_col_cnt + 16'd1;
        r_x       <= w_x_nxt;
        r_y       <= w_y_nxt;
        r_dx      <= r_dx ^ w_x_hit;
        r_dy      <= r_dy ^ w_y_hit;
        r_bounce  <= {w_y_hit, w_x_hit};
      end
    end
  for (genvar c = 0; c < 3; c++) begin : g_col
    localparam logic [COLOR_W:0] ST = (COLOR_W + 1)'(STEPS[c]);
    logic [COLOR_W-1:0] r_c;
    logic               r_d;
    logic [COLOR_W:0]   w_up;
    logic               w_hit;
    assign w_up  = {1'b0, r_c} + ST;
    assign w_hit = r_d ? ({1'b0, r_c} < ST) : (w_up > C_MAX);
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_c <= '0;
        r_d <= 1'b0;
      end else if (w_col_stb) begin
        r_c <= w_hit ? (r_d ? '0 : C_MAX[COLOR_W-1:0]) : (r_d ? r_c - ST[COLOR_W-1:0] : w_up[COLOR_W-1:0]);
        r_d <= r_d ^ w_hit;
      end
    assign w_col[c] = r_c;
  end
  assign bus.o_centre_x = r_x;
  assign bus.o_centre_y = r_y;
  assign bus.o_dir_x    = r_dx;
  assign bus.o_dir_y    = r_dy;
  assign bus.o_red      = w_col[0];
  assign bus.o_green    = w_col[1];
  assign bus.o_blue     = w_col[2];
  assign bus.o_bounce   = r_bounce;
endmodule

// File: tb/tb_bounce_animator.sv
// tb_bounce_animator: two configurations checked every cycle against a plain arithmetic model
module tb_bounce_animator;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, en = 1'b0;
  int tests = 0, fails = 0;
  localparam int MD [2] = '{1, 4};
  localparam int CD [2] = '{16, 1};
  localparam longint RST = longint'({10'd77, 9'd77, 16'd0});
  bounce_animator_if i0 ();
  bounce_animator_if i1 ();
  assign i0.i_frame_tick = tick;
  assign i0.i_enable     = en;
  assign i1.i_frame_tick = tick;
  assign i1.i_enable     = en;
  bounce_animator dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  bounce_animator #(.MOVE_DIV(4), .COLOR_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;

  int mx [2], my [2], mdx [2], mdy [2], mmc [2], mcc [2], mb [2];
  int mcol [2][3], mcd [2][3];

  function automatic void reflect(inout int p, inout int d, input int st, input int lo, input int hi, output int hit);
    hit = 0;
    if (d == 0) begin
      if (p + st > hi) begin p = hi; d = 1; hit = 1; end
      else p = p + st;
    end else begin
      if (p - st < lo) begin p = lo; d = 0; hit = 1; end
      else p = p - st;
    end
  endfunction

  function automatic void step(int k);
    int hx, hy, hc;
    mb[k] = 0;
    if (!rst) begin
      mx[k] = 77; my[k] = 77; mdx[k] = 0; mdy[k] = 0; mmc[k] = 0; mcc[k] = 0;
      for (int c = 0; c < 3; c++) begin mcol[k][c] = 0; mcd[k][c] = 0; end
    end else if (tick && en) begin
      if (mmc[k] == MD[k] - 1) begin
        mmc[k] = 0;
        reflect(mx[k], mdx[k], 3, 77, 562, hx);
        reflect(my[k], mdy[k], 1, 77, 402, hy);
        mb[k] = hx + 2 * hy;
        if (mcc[k] == CD[k] - 1) begin
          mcc[k] = 0;
          for (int c = 0; c < 3; c++) reflect(mcol[k][c], mcd[k][c], c + 1, 0, 15, hc);
        end else mcc[k] = mcc[k] + 1;
      end else mmc[k] = mmc[k] + 1;
    end
  endfunction

  function automatic longint pack0();
    return longint'({i0.o_centre_x, i0.o_centre_y, i0.o_dir_x, i0.o_dir_y, i0.o_red, i0.o_green, i0.o_blue, i0.o_bounce});
  endfunction
  function automatic longint pack1();
    return longint'({i1.o_centre_x, i1.o_centre_y, i1.o_dir_x, i1.o_dir_y, i1.o_red, i1.o_green, i1.o_blue, i1.o_bounce});
  endfunction
  function automatic longint model(int k);
    return longint'({10'(mx[k]), 9'(my[k]), 1'(mdx[k]), 1'(mdy[k]), 4'(mcol[k][0]), 4'(mcol[k][1]), 4'(mcol[k][2]), 2'(mb[k])});
  endfunction

  task automatic chk(string name, longint got, longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
    #1;
    chk("model0", pack0(), model(0));
    chk("model1", pack1(), model(1));
  end

  task automatic pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset0", pack0(), RST);
    chk("reset1", pack1(), RST);
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) pulse();
    chk("div4_pre_x", longint'(i1.o_centre_x), 77);
    pulse();
    chk("div4_t4_x", longint'(i1.o_centre_x), 80);
    repeat (6) pulse();
    chk("t10_x", longint'(i0.o_centre_x), 107);
    chk("t10_y", longint'(i0.o_centre_y), 87);
    chk("t10_dir", longint'({i0.o_dir_x, i0.o_dir_y, i0.o_bounce}), 0);
    chk("t10_x1", longint'(i1.o_centre_x), 83);
    chk("t10_blue1", longint'(i1.o_blue), 6);
    repeat (2) pulse();
    chk("t12_x1", longint'(i1.o_centre_x), 86);
    repeat (8) pulse();
    chk("t20_rgb1", longint'({i1.o_red, i1.o_green, i1.o_blue}), longint'({4'd5, 4'd10, 4'd15}));
    repeat (4) pulse();
    chk("t24_rgb1", longint'({i1.o_red, i1.o_green, i1.o_blue}), longint'({4'd6, 4'd12, 4'd15}));
    repeat (4) pulse();
    chk("t28_rgb1", longint'({i1.o_red, i1.o_green, i1.o_blue}), longint'({4'd7, 4'd14, 4'd12}));
    repeat (4) pulse();
    chk("t32_rgb1", longint'({i1.o_red, i1.o_green, i1.o_blue}), longint'({4'd8, 4'd15, 4'd9}));
    repeat (129) pulse();
    chk("t161_x", longint'({i0.o_centre_x, i0.o_dir_x}), longint'({10'd560, 1'b0}));
    pulse();
    chk("t162_x", longint'({i0.o_centre_x, i0.o_dir_x}), longint'({10'd562, 1'b1}));
    chk("t162_bounce", longint'(i0.o_bounce), 1);
    @(negedge clk);
    chk("t162_bounce_end", longint'(i0.o_bounce), 0);
    pulse();
    chk("t163_x", longint'(i0.o_centre_x), 559);
    en = 1'b0;
    repeat (5) pulse();
    chk("frozen_x0", longint'(i0.o_centre_x), 559);
    chk("frozen_x1", longint'(i1.o_centre_x), 197);
    en = 1'b1;
    pulse();
    chk("resume_x0", longint'(i0.o_centre_x), 556);
    chk("resume_x1", longint'(i1.o_centre_x), 200);
    for (int i = 0; i < 20000; i++) begin
      tick = ($urandom_range(2) == 0);
      en   = ($urandom_range(7) != 0);
      if ($urandom_range(2999) == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("async_rst0", pack0(), RST);
        chk("async_rst1", pack1(), RST);
        @(negedge clk);
        rst = 1'b1;
      end else @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
